// File: rtl/deser_pkg.sv
// Shared constants and helpers for the SDR deserializer.
package deser_pkg;

  localparam int unsigned DESER_MIN_WIDTH = 2;
  localparam int unsigned DESER_MAX_WIDTH = 8;

  // Bit counter width for a given word width: ceil(log2(width)), at least 1.
  function automatic int unsigned deser_cnt_w(input int unsigned width);
    int unsigned w;
    for (w = 1; (32'd1 << w) < width; w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/deser_bitcnt.sv
// Bit position counter: counts enabled edges 0..last and wraps explicitly at last.
module deser_bitcnt #(
  parameter int unsigned CNT_W = 3,
  parameter int unsigned LAST  = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hold,
  output logic wrap_c
);

  logic [CNT_W-1:0] cnt;

  assign wrap_c = (cnt == CNT_W'(LAST));

  // Explicit wrap so non-power-of-two widths never visit out-of-range values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && !hold) begin
      cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/deser_sdr.sv
// Single-data-rate serial-to-parallel deserializer with bitslip word alignment.
module deser_sdr
  import deser_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_Q     = {DATA_WIDTH{1'b0}}
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  CE,
  input  logic                  D,
  input  logic                  BITSLIP,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  VALID,
  output logic                  SLIP_BUSY
);

  localparam int unsigned CNT_W = deser_cnt_w(DATA_WIDTH);

  if (DATA_WIDTH < DESER_MIN_WIDTH || DATA_WIDTH > DESER_MAX_WIDTH) begin : g_bad_width
    $error("deser_sdr: DATA_WIDTH must be in 2..8");
  end

  // Only the bits that can still land in a future word are kept; the oldest
  // shifted-out bit never reaches Q.
  logic [DATA_WIDTH-2:0] sr;
  logic [DATA_WIDTH-1:0] word_c;
  logic                  lock;
  logic                  slip_acc_c;
  logic                  wrap_c;

  assign word_c     = {sr, D};
  assign slip_acc_c = CE && BITSLIP && !lock;
  assign SLIP_BUSY  = lock;

  deser_bitcnt #(
    .CNT_W (CNT_W),
    .LAST  (DATA_WIDTH - 1)
  ) u_bitcnt (
    .clk    (CLK),
    .rst_n  (RSTN),
    .en     (CE),
    .hold   (slip_acc_c),
    .wrap_c (wrap_c)
  );

  // A slip wins over word completion: the counter holds and the word is skipped.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sr    <= '0;
      lock  <= 1'b0;
      Q     <= INIT_Q;
      VALID <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (CE) begin
        sr <= word_c[DATA_WIDTH-2:0];
        if (slip_acc_c) begin
          lock <= 1'b1;
        end else if (wrap_c) begin
          Q     <= word_c;
          VALID <= 1'b1;
          lock  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_deser_sdr.sv
// Directed bench for deser_sdr: vector table plus bitslip, lockout and odd-width sequences.
module tb_deser_sdr;

  logic       clk = 1'b0;
  logic       rstn;
  logic       ce, d, bs;
  logic [7:0] q;
  logic       valid, busy;
  logic       ce5, d5, bs5;
  logic [4:0] q5;
  logic       valid5, busy5;

  always #5 clk = ~clk;

  deser_sdr #(.DATA_WIDTH(8)) dut (
    .CLK(clk), .RSTN(rstn), .CE(ce), .D(d), .BITSLIP(bs),
    .Q(q), .VALID(valid), .SLIP_BUSY(busy)
  );

  deser_sdr #(.DATA_WIDTH(5), .INIT_Q(5'h0A)) dut5 (
    .CLK(clk), .RSTN(rstn), .CE(ce5), .D(d5), .BITSLIP(bs5),
    .Q(q5), .VALID(valid5), .SLIP_BUSY(busy5)
  );

  typedef struct {
    logic       rstn;
    logic       ce;
    logic       d;
    logic       bs;
    logic       v;
    logic [7:0] q;
    logic       b;
  } vec_t;

  vec_t       tbl[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         sidx   = 0;
  int         n, vcount, rises, back2back, first_v, second_v;
  logic       busy_ok, prev_busy, prev_valid;
  logic [7:0] pat8 = 8'hA5;
  logic [7:0] gw   = 8'hA5;
  logic [4:0] pat5 = 5'b11001;
  logic [7:0] expw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic void add(input logic r, input logic c, input logic dd, input logic s,
                              input logic v, input logic [7:0] qq, input logic b);
    vec_t e;
    e.rstn = r; e.ce = c; e.d = dd; e.bs = s; e.v = v; e.q = qq; e.b = b;
    tbl.push_back(e);
  endfunction

  // Eight enabled bits MSB first; VALID and the new word appear on the last one.
  function automatic void add_word(input logic [7:0] w, input logic [7:0] qprev);
    for (int i = 7; i >= 0; i--)
      add(1'b1, 1'b1, w[i], 1'b0, (i == 0), (i == 0) ? w : qprev, 1'b0);
  endfunction

  // One enabled edge of the continuous 0xA5 stream on the 8-bit instance.
  task automatic edge8(input logic bs_i);
    int idx;
    @(negedge clk);
    idx = 7 - (sidx % 8);
    ce = 1'b1; d = pat8[idx]; bs = bs_i;
    sidx++;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; ce = 1'b0; d = 1'b0; bs = 1'b0;
    ce5 = 1'b0; d5 = 1'b0; bs5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst5_state", 32'({valid5, q5, busy5}), 32'({1'b0, 5'h0A, 1'b0}));

    // Vector table: reset, basic word, CE gaps, mid-word reset.
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    add_word(8'hA5, 8'h00);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0);
    add_word(8'h3C, 8'hA5);
    for (int i = 7; i >= 0; i--) begin
      add(1'b1, 1'b1, gw[i], 1'b0, (i == 0), (i == 0) ? 8'hA5 : 8'h3C, 1'b0);
      if (i == 6 || i == 3)
        repeat (3) add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0);
    end
    repeat (5) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    add_word(8'h69, 8'h00);

    foreach (tbl[i]) begin
      @(negedge clk);
      rstn = tbl[i].rstn; ce = tbl[i].ce; d = tbl[i].d; bs = tbl[i].bs;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), 32'({valid, q, busy}),
            32'({tbl[i].v, tbl[i].q, tbl[i].b}));
    end

    // Continuous 0xA5 stream, aligned start.
    sidx = 0;
    repeat (8) edge8(1'b0);
    check("stream_align", 32'({valid, q}), 32'({1'b1, 8'hA5}));

    // One slip per word, eight times; each rotates the word left by one bit.
    for (int j = 1; j <= 8; j++) begin
      expw = (pat8 << j) | (pat8 >> (8 - j));
      repeat (3) edge8(1'b0);
      edge8(1'b1);
      check($sformatf("slip%0d_busy_rise", j), 32'({valid, busy}), 32'({1'b0, 1'b1}));
      n = 0; busy_ok = 1'b1;
      while (!valid && n < 20) begin
        edge8(1'b0);
        n++;
        if (!valid && !busy) busy_ok = 1'b0;
      end
      check($sformatf("slip%0d_busy_hold", j), 32'(busy_ok), 32'd1);
      check($sformatf("slip%0d_gap", j), 32'(n), 32'd5);
      check($sformatf("slip%0d_word", j), 32'({q, busy}), 32'({expw, 1'b0}));
      n = 0;
      do begin
        edge8(1'b0);
        n++;
      end while (!valid && n < 20);
      check($sformatf("slip%0d_period", j), 32'(n), 32'd8);
      check($sformatf("slip%0d_next_word", j), 32'(q), 32'(expw));
    end
    check("realigned", 32'(q), 32'h0A5);

    // BITSLIP held high: one slip per emitted word.
    vcount = 0; rises = 0; back2back = 0; first_v = 0; second_v = 0;
    prev_busy = busy; prev_valid = valid;
    for (int k = 1; k <= 20; k++) begin
      edge8(1'b1);
      if (busy && !prev_busy) rises++;
      if (valid && prev_valid) back2back++;
      if (valid) begin
        vcount++;
        if (vcount == 1) first_v = k;
        if (vcount == 2) second_v = k;
        check($sformatf("lock_word%0d", vcount), 32'(q), (vcount == 1) ? 32'h4B : 32'h96);
      end
      prev_busy = busy; prev_valid = valid;
    end
    check("lock_valid_count", 32'(vcount), 32'd2);
    check("lock_slip_count", 32'(rises), 32'd3);
    check("lock_back2back", 32'(back2back), 32'd0);
    check("lock_first_valid", 32'(first_v), 32'd9);
    check("lock_second_valid", 32'(second_v), 32'd18);
    @(negedge clk);
    ce = 1'b0; bs = 1'b0;

    // Width 5: 1,1,0,0,1 repeated gives 0x19 every 5 edges.
    for (int k = 1; k <= 20; k++) begin
      int idx;
      @(negedge clk);
      idx = 4 - ((k - 1) % 5);
      ce5 = 1'b1; d5 = pat5[idx]; bs5 = 1'b0;
      @(posedge clk); #1;
      check($sformatf("w5_%0d", k), 32'({valid5, q5, busy5}),
            32'({(k % 5 == 0), (k < 5) ? 5'h0A : 5'h19, 1'b0}));
    end

    // Width 5: slip on the completion edge suppresses that word, then one bit later.
    for (int k = 1; k <= 6; k++) begin
      int idx;
      @(negedge clk);
      idx = 4 - ((k - 1) % 5);
      ce5 = 1'b1; d5 = pat5[idx]; bs5 = (k == 5);
      @(posedge clk); #1;
      if (k == 5)
        check("w5_slip_on_wrap", 32'({valid5, q5, busy5}), 32'({1'b0, 5'h19, 1'b1}));
      if (k == 6)
        check("w5_after_slip", 32'({valid5, q5, busy5}), 32'({1'b1, 5'h13, 1'b0}));
    end
    @(negedge clk);
    ce5 = 1'b0; bs5 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
